counter_event_monitor: RTL

Downstream observer of the `BIT_WIDTH` up/down counter. It samples the counter value and direction every cycle and detects wrap-around in either direction and matches against a programmable compare value. Each event is timestamped and queued in a small FIFO, which the consumer drains over a valid/ready handshake. It sits between the counter and any status/interrupt logic, and never drives the counter.

---
 rtl/counter_event_monitor.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/counter_event_monitor.sv
// counter_event_monitor
// Passive observer of an up/down counter. Detects wrap-around in either
// direction and edge-triggered matches against a programmable value, stamps
// each event with a free-running timestamp, and queues it in a small
// show-ahead FIFO that a consumer drains over a valid/ready handshake.
//
// Handshake: evt_valid is high whenever the FIFO head holds an event; the head
// is consumed on a rising edge where evt_valid and evt_ready are both high.
// While evt_valid=1 and evt_ready=0 the head (evt_code/evt_stamp) is held
// stable. evt_ready is ignored while evt_valid=0.
module counter_event_monitor #(
  parameter int BIT_WIDTH = 4,
  parameter int STAMP_W   = 8,
  parameter int DEPTH     = 4
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] count,
  input  logic                 chnge,
  input  logic [BIT_WIDTH-1:0] cmp_value,
  input  logic                 cmp_en,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [1:0]           evt_code,
  output logic [STAMP_W-1:0]   evt_stamp,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 2 + STAMP_W;

  localparam logic [BIT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [BIT_WIDTH-1:0] CNT_ZERO = '0;

  localparam logic [1:0] CODE_WRAP_UP = 2'b01;
  localparam logic [1:0] CODE_WRAP_DN = 2'b10;
  localparam logic [1:0] CODE_MATCH   = 2'b11;

  logic [BIT_WIDTH-1:0] prev_count;
  logic                 prev_valid;
  logic [STAMP_W-1:0]   stamp;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;

  logic                 wrap_up;
  logic                 wrap_dn;
  logic                 match;
  logic                 push_req;
  logic [1:0]           push_code;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 do_pop;
  logic                 do_push;
  logic                 do_drop;

  // Event detection against the previous sample; wraps take priority over match
  always_comb begin
    wrap_up   = 1'b0;
    wrap_dn   = 1'b0;
    match     = 1'b0;
    push_req  = 1'b0;
    push_code = 2'b00;
    if (prev_valid) begin
      wrap_up = !chnge && (prev_count == CNT_MAX)  && (count == CNT_ZERO);
      wrap_dn =  chnge && (prev_count == CNT_ZERO) && (count == CNT_MAX);
      match   = cmp_en && (count == cmp_value) && (count != prev_count);
    end
    if (wrap_up) begin
      push_req  = 1'b1;
      push_code = CODE_WRAP_UP;
    end else if (wrap_dn) begin
      push_req  = 1'b1;
      push_code = CODE_WRAP_DN;
    end else if (match) begin
      push_req  = 1'b1;
      push_code = CODE_MATCH;
    end
  end

  // FIFO occupancy and the push/pop/drop decision for this cycle
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop     = !fifo_empty && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    do_push    = push_req && (!fifo_full || do_pop);
    do_drop    = push_req && fifo_full && !do_pop;
  end

  // Sampling of the counter and the free-running timestamp
  always_ff @(posedge CLK) begin
    if (reset) begin
      prev_count <= '0;
      prev_valid <= 1'b0;
      stamp      <= '0;
    end else begin
      prev_count <= count;
      prev_valid <= 1'b1;
      stamp      <= stamp + STAMP_W'(1);
    end
  end

  // FIFO storage and pointers; storage is cleared so the head reads zero after reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= {push_code, stamp};
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge CLK) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (do_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Show-ahead head: outputs come straight from registered pointers and storage
  always_comb begin
    evt_valid = !fifo_empty;
    evt_code  = mem[rd_ptr[AW-1:0]][ENTRY_W-1:STAMP_W];
    evt_stamp = mem[rd_ptr[AW-1:0]][STAMP_W-1:0];
  end

endmodule
